// File: rtl/icache_fetcher_pkg.sv
// icache_fetcher_pkg
//   Shared definitions for the instruction-fetch front end: word type,
//   default cache geometry and the fetcher state encoding.
package icache_fetcher_pkg;

    typedef logic [31:0] data_t;

    localparam data_t       ZERO_WORD              = '0;
    localparam logic        TRUE                   = 1'b1;
    localparam logic        FALSE                  = 1'b0;
    localparam int unsigned ICACHE_INDEX_BITS_DEF  = 8;

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/icache_array.sv
// icache_array
//   Direct-mapped, one-word-per-line instruction cache storage.
//   Ports:
//     clk, rst              clock, synchronous active-high reset (clears valid bits)
//     i_we                  write enable (fill)
//     i_widx/i_wtag/i_wdata fill index, tag and data word
//     i_ridx                combinational read index
//     o_rvalid/o_rtag/o_rdata  line contents at i_ridx
module icache_array
    import icache_fetcher_pkg::*;
#(
    parameter int unsigned INDEX_BITS = ICACHE_INDEX_BITS_DEF,
    parameter int unsigned TAG_BITS   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [INDEX_BITS-1:0] i_widx,
    input  logic [TAG_BITS-1:0]   i_wtag,
    input  data_t                 i_wdata,
    input  logic [INDEX_BITS-1:0] i_ridx,
    output logic                  o_rvalid,
    output logic [TAG_BITS-1:0]   o_rtag,
    output data_t                 o_rdata
);

    localparam int unsigned LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    r_valid;
    logic [TAG_BITS-1:0] r_tag  [LINES];
    data_t               r_data [LINES];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_widx] <= TRUE;
        end
    end

    // Tag/data need no reset: a line is only consulted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_widx]  <= i_wtag;
            r_data[i_widx] <= i_wdata;
        end
    end

    assign o_rvalid = r_valid[i_ridx];
    assign o_rtag   = r_tag[i_ridx];
    assign o_rdata  = r_data[i_ridx];

endmodule

// File: rtl/icache_fetcher.sv
// icache_fetcher
//   Instruction-fetch front end: holds the PC, looks it up in a direct-mapped
//   cache, delivers one instruction per cycle on hits, fetches single words
//   from memCtrl on misses, and redirects on ROB misprediction (xbp).
//   Ports:
//     clk, rst, rdy                   clock, sync active-high reset, global enable
//     out_mem_flag/out_mem_addr       one-cycle fetch request and its word address
//     in_mem_flag/in_mem_data         memCtrl completion pulse and fetched word
//     in_issue_full                   issue stage cannot accept this cycle
//     out_inst_valid/out_inst/out_pc  delivered instruction pulse, word and PC
//     in_rob_xbp/in_rob_xbp_pc        misprediction flush and redirect target
module icache_fetcher
    import icache_fetcher_pkg::*;
#(
    parameter int unsigned ICACHE_INDEX_BITS = ICACHE_INDEX_BITS_DEF,
    parameter int unsigned ADDR_BITS         = 18,
    parameter logic [31:0] RESET_PC          = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        out_mem_flag,
    output logic [31:0] out_mem_addr,
    input  logic        in_mem_flag,
    input  logic [31:0] in_mem_data,
    input  logic        in_issue_full,
    output logic        out_inst_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    input  logic        in_rob_xbp,
    input  logic [31:0] in_rob_xbp_pc
);

    localparam int unsigned TAG_BITS = ADDR_BITS - ICACHE_INDEX_BITS - 2;

    fetch_state_e r_state, w_state_next;
    logic [31:0]  r_pc;
    logic         r_mem_flag;
    logic [31:0]  r_mem_addr;
    logic         r_inst_valid;
    data_t        r_inst;
    logic [31:0]  r_out_pc;

    logic [ICACHE_INDEX_BITS-1:0] w_idx, w_fill_idx;
    logic [TAG_BITS-1:0]          w_tag, w_fill_tag, w_rtag;
    logic                         w_rvalid, w_hit;
    data_t                        w_rdata;
    logic                         w_emit, w_req, w_fill, w_we;

    assign w_idx      = r_pc[ICACHE_INDEX_BITS+1:2];
    assign w_tag      = r_pc[ADDR_BITS-1:ICACHE_INDEX_BITS+2];
    assign w_fill_idx = r_mem_addr[ICACHE_INDEX_BITS+1:2];
    assign w_fill_tag = r_mem_addr[ADDR_BITS-1:ICACHE_INDEX_BITS+2];
    assign w_hit      = w_rvalid && (w_rtag == w_tag);
    assign w_we       = w_fill && rdy && !rst;

    icache_array #(
        .INDEX_BITS (ICACHE_INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_we),
        .i_widx   (w_fill_idx),
        .i_wtag   (w_fill_tag),
        .i_wdata  (in_mem_data),
        .i_ridx   (w_idx),
        .o_rvalid (w_rvalid),
        .o_rtag   (w_rtag),
        .o_rdata  (w_rdata)
    );

    always_comb begin
        w_state_next = r_state;
        w_emit       = FALSE;
        w_req        = FALSE;
        w_fill       = FALSE;
        case (r_state)
            IDLE: begin
                if (w_hit) begin
                    w_emit = !in_issue_full;
                end else begin
                    w_req        = TRUE;
                    w_state_next = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (in_mem_flag) begin
                    w_fill       = TRUE;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
        // Flush overrides emission and requests, but a coincident return still fills.
        if (in_rob_xbp) begin
            w_state_next = IDLE;
            w_emit       = FALSE;
            w_req        = FALSE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else if (rdy) begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_mem_flag   <= FALSE;
            r_mem_addr   <= ZERO_WORD;
            r_inst_valid <= FALSE;
            r_inst       <= ZERO_WORD;
            r_out_pc     <= ZERO_WORD;
        end else if (rdy) begin
            r_inst_valid <= w_emit;
            r_mem_flag   <= w_req;
            if (in_rob_xbp) begin
                r_pc <= in_rob_xbp_pc;
            end else if (w_emit) begin
                r_inst   <= w_rdata;
                r_out_pc <= r_pc;
                r_pc     <= r_pc + 32'd4;
            end
            if (w_req) begin
                r_mem_addr <= {r_pc[31:2], 2'b00};
            end
        end
    end

    assign out_mem_flag   = r_mem_flag;
    assign out_mem_addr   = r_mem_addr;
    assign out_inst_valid = r_inst_valid;
    assign out_inst       = r_inst;
    assign out_pc         = r_out_pc;

endmodule
